// File: rtl/usb_tx_sched.sv
// usb_tx_sched: packet-granular arbiter between token and data TX sources with inter-packet gap and length policing
module usb_tx_sched #(
  parameter int IPG_CYCLES    = 4,
  parameter int MAX_PKT_BYTES = 1027
) (
  input  logic clk,
  input  logic rst,
  input  logic s_to_valid,
  input  logic s_to_sop,
  input  logic s_to_eop,
  output logic s_to_ready,
  output logic m_to_valid,
  input  logic m_to_ready,
  input  logic s_lt_valid,
  input  logic s_lt_sop,
  input  logic s_lt_eop,
  input  logic s_lt_cancle,
  output logic s_lt_ready,
  output logic m_lt_valid,
  output logic m_lt_cancle,
  input  logic m_lt_ready,
  output logic tx_data_on,
  output logic busy,
  output logic pkt_done,
  output logic err_frame,
  output logic err_len
);
  localparam int BW = $clog2(MAX_PKT_BYTES + 1);
  localparam int GW = IPG_CYCLES > 1 ? $clog2(IPG_CYCLES) : 1;
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_PKT_BYTES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(IPG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TOK, DATA, DROP, GAP} state_t;

  state_t state_q, state_d;
  logic grant_to_q, grant_to_d, grant_lt_q, grant_lt_d, tx_data_on_q, tx_data_on_d;
  logic pkt_done_q, pkt_done_d, err_frame_q, err_frame_d, err_len_q, err_len_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic idle, to_disc, lt_disc, to_fire, lt_fire, at_max, arb;

  assign idle        = state_q == IDLE;
  assign to_disc     = idle && s_to_valid && !s_to_sop;
  assign lt_disc     = idle && s_lt_valid && !s_lt_sop;
  assign at_max      = byte_cnt_q == MAX_CNT;
  assign s_to_ready  = (grant_to_q && m_to_ready) || to_disc;
  assign s_lt_ready  = (grant_lt_q && m_lt_ready) || state_q == DROP || lt_disc;
  assign m_to_valid  = s_to_valid && grant_to_q;
  assign m_lt_valid  = s_lt_valid && grant_lt_q;
  assign m_lt_cancle = grant_lt_q && (s_lt_cancle || at_max);
  assign to_fire     = s_to_valid && s_to_ready;
  assign lt_fire     = s_lt_valid && s_lt_ready;
  assign tx_data_on  = tx_data_on_q;
  assign busy        = !idle;
  assign pkt_done    = pkt_done_q;
  assign err_frame   = err_frame_q;
  assign err_len     = err_len_q;

  always_comb begin
    state_d      = state_q;
    grant_to_d   = grant_to_q;
    grant_lt_d   = grant_lt_q;
    tx_data_on_d = tx_data_on_q;
    gap_cnt_d    = gap_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    pkt_done_d   = 1'b0;
    err_frame_d  = 1'b0;
    err_len_d    = 1'b0;
    arb          = 1'b0;
    case (state_q)
      IDLE: begin
        arb         = 1'b1;
        err_frame_d = to_disc || lt_disc;
      end
      TOK: if (to_fire && s_to_eop) begin
        state_d    = GAP;
        grant_to_d = 1'b0;
        gap_cnt_d  = GAP_LOAD;
        pkt_done_d = 1'b1;
      end
      DATA: if (lt_fire) begin
        byte_cnt_d  = byte_cnt_q + BW'(1);
        err_frame_d = s_lt_sop && byte_cnt_q != '0;
        err_len_d   = at_max;
        if (s_lt_eop || m_lt_cancle) begin
          state_d    = s_lt_eop ? GAP : DROP;
          grant_lt_d = 1'b0;
          gap_cnt_d  = GAP_LOAD;
          pkt_done_d = s_lt_eop && !m_lt_cancle;
        end
      end
      DROP: if (lt_fire && s_lt_eop) begin
        state_d   = GAP;
        gap_cnt_d = GAP_LOAD;
      end
      GAP: begin
        arb       = gap_cnt_q == '0;
        gap_cnt_d = arb ? '0 : gap_cnt_q - GW'(1);
        state_d   = arb ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
    if (arb && s_to_valid && s_to_sop) begin
      state_d      = TOK;
      grant_to_d   = 1'b1;
      tx_data_on_d = 1'b0;
    end else if (arb && s_lt_valid && s_lt_sop) begin
      state_d      = DATA;
      grant_lt_d   = 1'b1;
      tx_data_on_d = 1'b1;
      byte_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_to_q   <= 1'b0;
      grant_lt_q   <= 1'b0;
      tx_data_on_q <= 1'b0;
      gap_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      pkt_done_q   <= 1'b0;
      err_frame_q  <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_to_q   <= grant_to_d;
      grant_lt_q   <= grant_lt_d;
      tx_data_on_q <= tx_data_on_d;
      gap_cnt_q    <= gap_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      pkt_done_q   <= pkt_done_d;
      err_frame_q  <= err_frame_d;
      err_len_q    <= err_len_d;
    end
  end
endmodule

// File: tb/tb_usb_tx_sched.sv
// tb_usb_tx_sched: scoreboard bench; dut_a uses the default length limit, dut_b a limit of 8 beats
module tb_usb_tx_sched;
  localparam logic [2:0] EV_NONE = 3'd0, EV_TO = 3'd1, EV_LT = 3'd2, EV_LTC = 3'd3;
  localparam logic [2:0] EV_DONE = 3'd4, EV_EFR = 3'd5, EV_ELEN = 3'd6;

  logic clk = 1'b0, rst = 1'b1, sel = 1'b0;
  logic to_valid = 1'b0, to_sop = 1'b0, to_eop = 1'b0;
  logic lt_valid = 1'b0, lt_sop = 1'b0, lt_eop = 1'b0, lt_cancle = 1'b0;
  logic m_to_ready = 1'b1, m_lt_ready = 1'b1;
  logic [1:0] s_to_ready, m_to_valid, s_lt_ready, m_lt_valid, m_lt_cancle;
  logic [1:0] tx_data_on, busy, pkt_done, err_frame, err_len;
  logic [2:0] q0[$], q1[$];
  int checks = 0, failures = 0, cyc = 0;
  int f1, f2, f3, tf, df;
  bit tog;

  usb_tx_sched #(.IPG_CYCLES(4), .MAX_PKT_BYTES(1027)) dut_a (
    .clk(clk), .rst(rst),
    .s_to_valid(to_valid && !sel), .s_to_sop(to_sop), .s_to_eop(to_eop),
    .s_to_ready(s_to_ready[0]), .m_to_valid(m_to_valid[0]), .m_to_ready(m_to_ready),
    .s_lt_valid(lt_valid && !sel), .s_lt_sop(lt_sop), .s_lt_eop(lt_eop), .s_lt_cancle(lt_cancle),
    .s_lt_ready(s_lt_ready[0]), .m_lt_valid(m_lt_valid[0]), .m_lt_cancle(m_lt_cancle[0]),
    .m_lt_ready(m_lt_ready), .tx_data_on(tx_data_on[0]), .busy(busy[0]),
    .pkt_done(pkt_done[0]), .err_frame(err_frame[0]), .err_len(err_len[0])
  );

  usb_tx_sched #(.IPG_CYCLES(4), .MAX_PKT_BYTES(8)) dut_b (
    .clk(clk), .rst(rst),
    .s_to_valid(to_valid && sel), .s_to_sop(to_sop), .s_to_eop(to_eop),
    .s_to_ready(s_to_ready[1]), .m_to_valid(m_to_valid[1]), .m_to_ready(m_to_ready),
    .s_lt_valid(lt_valid && sel), .s_lt_sop(lt_sop), .s_lt_eop(lt_eop), .s_lt_cancle(lt_cancle),
    .s_lt_ready(s_lt_ready[1]), .m_lt_valid(m_lt_valid[1]), .m_lt_cancle(m_lt_cancle[1]),
    .m_lt_ready(m_lt_ready), .tx_data_on(tx_data_on[1]), .busy(busy[1]),
    .pkt_done(pkt_done[1]), .err_frame(err_frame[1]), .err_len(err_len[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] e);
    if (e != EV_NONE) begin
      if (sel) q1.push_back(e);
      else q0.push_back(e);
    end
  endtask

  task automatic take(input int i, input logic [2:0] got);
    logic [2:0] e;
    checks++;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      failures++;
      $display("FAIL sb_dut%0d unexpected event got=%0d exp=none", i, got);
    end else begin
      if (i == 0) e = q0.pop_front();
      else e = q1.pop_front();
      if (e !== got) begin
        failures++;
        $display("FAIL sb_dut%0d event got=%0d exp=%0d", i, got, e);
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (err_len[i]) take(i, EV_ELEN);
      if (err_frame[i]) take(i, EV_EFR);
      if (pkt_done[i]) take(i, EV_DONE);
      if (m_to_valid[i] && m_to_ready) take(i, EV_TO);
      if (m_lt_valid[i] && m_lt_ready) take(i, m_lt_cancle[i] ? EV_LTC : EV_LT);
    end
  end

  task automatic beat(input bit is_to, input bit sop, input bit eop, input logic [2:0] e0,
                      input logic [2:0] e1, output int fc);
    bit fired = 1'b0;
    if (is_to) begin
      to_valid = 1'b1;
      to_sop = sop;
      to_eop = eop;
    end else begin
      lt_valid = 1'b1;
      lt_sop = sop;
      lt_eop = eop;
    end
    for (int n = 0; n < 200 && !fired; n++) begin
      @(negedge clk);
      fired = is_to ? s_to_ready[sel] : s_lt_ready[sel];
      if (fired) begin
        fc = cyc;
        push(e0);
        push(e1);
      end
      @(posedge clk);
      #1;
    end
    if (!fired) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout is_to=%0d got=no_ready exp=ready", is_to);
    end
    if (is_to) {to_valid, to_sop, to_eop} = 3'b000;
    else {lt_valid, lt_sop, lt_eop} = 3'b000;
  endtask

  task automatic wait_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {to_valid, to_sop, to_eop, lt_valid, lt_sop, lt_eop, lt_cancle} = 7'd0;
    m_to_ready = 1'b1;
    m_lt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk("reset_outputs", 32'({tx_data_on[i], busy[i], pkt_done[i], err_frame[i], err_len[i],
          s_to_ready[i], s_lt_ready[i], m_to_valid[i], m_lt_valid[i], m_lt_cancle[i]}), 0);
    // token packet
    beat(1'b1, 1'b1, 1'b0, EV_TO, EV_NONE, f1);
    beat(1'b1, 1'b0, 1'b0, EV_TO, EV_NONE, f2);
    beat(1'b1, 1'b0, 1'b1, EV_TO, EV_DONE, f3);
    chk("tok_consecutive", 32'(f3 - f1), 2);
    chk("tok_txon", 32'(tx_data_on[0]), 0);
    wait_cyc(f3 + 4);
    chk("tok_busy_gap", 32'(busy[0]), 1);
    wait_cyc(f3 + 5);
    chk("tok_busy_idle", 32'(busy[0]), 0);
    // simultaneous requests
    do_reset();
    fork
      begin
        beat(1'b1, 1'b1, 1'b0, EV_TO, EV_NONE, f1);
        beat(1'b1, 1'b0, 1'b1, EV_TO, EV_DONE, tf);
      end
      begin
        beat(1'b0, 1'b1, 1'b0, EV_LT, EV_NONE, df);
        beat(1'b0, 1'b0, 1'b0, EV_LT, EV_NONE, f2);
        beat(1'b0, 1'b0, 1'b1, EV_LT, EV_DONE, f3);
      end
    join
    chk("sim_token_first", 32'(f1 < df), 1);
    chk("sim_data_after_gap", 32'(df - tf), 5);
    chk("sim_txon", 32'(tx_data_on[0]), 1);
    // data with toggling backpressure
    do_reset();
    tog = 1'b1;
    fork
      begin
        for (int k = 1; k <= 10; k++)
          beat(1'b0, k == 1, k == 10, EV_LT, k == 10 ? EV_DONE : EV_NONE, f3);
        tog = 1'b0;
      end
      begin
        while (tog) begin
          @(negedge clk);
          if (busy[0] && tx_data_on[0] && lt_valid)
            chk("bp_ready_mirror", 32'(s_lt_ready[0]), 32'(m_lt_ready));
          @(posedge clk);
          #1 m_lt_ready = ~m_lt_ready;
        end
      end
    join
    m_lt_ready = 1'b1;
    chk("bp_byte_cnt", 32'(dut_a.byte_cnt_q), 10);
    // overflow on the 8-beat instance
    do_reset();
    sel = 1'b1;
    for (int k = 1; k <= 12; k++)
      beat(1'b0, k == 1, k == 12, k <= 8 ? EV_LT : (k == 9 ? EV_LTC : EV_NONE),
           k == 9 ? EV_ELEN : EV_NONE, f3);
    wait_cyc(f3 + 4);
    chk("ovf_busy_gap", 32'(busy[1]), 1);
    wait_cyc(f3 + 5);
    chk("ovf_busy_idle", 32'(busy[1]), 0);
    sel = 1'b0;
    // framing errors
    do_reset();
    beat(1'b0, 1'b0, 1'b0, EV_NONE, EV_EFR, f1);
    wait_cyc(f1 + 1);
    chk("frm_no_grant", 32'({busy[0], tx_data_on[0]}), 0);
    for (int k = 1; k <= 4; k++)
      beat(1'b0, k == 1 || k == 3, k == 4, EV_LT,
           k == 3 ? EV_EFR : (k == 4 ? EV_DONE : EV_NONE), f3);
    // reset in the middle of a data packet
    do_reset();
    for (int k = 1; k <= 4; k++) beat(1'b0, k == 1, 1'b0, EV_LT, EV_NONE, f3);
    lt_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_beat5_ready", 32'(s_lt_ready[0]), 1);
    push(EV_LT);
    @(posedge clk);
    #1;
    lt_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", 32'({s_to_ready[0], s_lt_ready[0], m_to_valid[0], m_lt_valid[0],
        m_lt_cancle[0], tx_data_on[0], busy[0], pkt_done[0], err_frame[0], err_len[0]}), 0);
    beat(1'b1, 1'b1, 1'b0, EV_TO, EV_NONE, f1);
    beat(1'b1, 1'b0, 1'b1, EV_TO, EV_DONE, f3);
    chk("rst_tok_txon", 32'(tx_data_on[0]), 0);
    wait_cyc(f3 + 5);
    chk("rst_tok_idle", 32'(busy[0]), 0);
    repeat (3) @(negedge clk);
    #2;
    chk("queue_a_drained", 32'(q0.size()), 0);
    chk("queue_b_drained", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_tx_sched.md
# usb_tx_sched

TX packet scheduler in front of the USB TX stream mux. Arbitrates between the token/handshake source (CRC5 path) and the link-layer data source, and drives the mux select `tx_data_on`. It holds the grant for a whole packet (SOP..EOP) and enforces an inter-packet gap. It also polices framing and data-packet length, cancelling oversize packets toward the PHY.

## Interface
- `IPG_CYCLES`, default 4: idle cycles inserted after each packet end. Legal range ≥1.
- `MAX_PKT_BYTES`, default 1027: maximum data-packet beats (PID + 1024 payload + CRC16).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `s_to_valid`, `s_to_sop`, `s_to_eop` in 1 each: token/handshake source beat qualifiers.
- `s_to_ready` out 1: ready back to the token source.
- `m_to_valid` out 1: gated valid to the mux token port.
- `m_to_ready` in 1: ready from the mux token port.
- `s_lt_valid`, `s_lt_sop`, `s_lt_eop`, `s_lt_cancle` in 1 each: link-layer data source qualifiers.
- `s_lt_ready` out 1: ready back to the data source.
- `m_lt_valid`, `m_lt_cancle` out 1 each: gated valid and cancel to the mux data port.
- `m_lt_ready` in 1: ready from the mux data port.
- `tx_data_on` out 1: mux select; 1 = data path. Registered.
- `busy` out 1: state ≠ IDLE.
- `pkt_done` out 1: one-cycle pulse on a packet's EOP transfer.
- `err_frame` out 1: one-cycle pulse on a framing violation.
- `err_len` out 1: one-cycle pulse on data-length overflow.

Data bytes do not pass through this block; only qualifiers and handshakes do.

## Operation
- States: IDLE, TOK, DATA, DROP, GAP. Registers: `grant_to`, `grant_lt`, `tx_data_on`, `gap_cnt`, and `byte_cnt` (width clog2(MAX_PKT_BYTES+1)).
- Fire definitions:
  - to_fire = `s_to_valid & s_to_ready`
  - lt_fire = `s_lt_valid & s_lt_ready`
- Path gating:
  - `m_to_valid = s_to_valid & grant_to`
  - `s_to_ready = grant_to & m_to_ready`
  - `m_lt_valid = s_lt_valid & grant_lt`
  - `s_lt_ready = grant_lt & m_lt_ready`, or 1 in DROP
- `m_lt_cancle = grant_lt & (s_lt_cancle | byte_cnt == MAX_PKT_BYTES)`.
- IDLE:
  - If `s_to_valid & s_to_sop`: go to TOK, set `grant_to=1`, `tx_data_on=0`.
  - Else if `s_lt_valid & s_lt_sop`: go to DATA, set `grant_lt=1`, `tx_data_on=1`, `byte_cnt=0`.
  - Token has priority when both request in the same cycle.
  - A valid beat without SOP in IDLE is discarded: its `s_*_ready` is 1 for that cycle, nothing is forwarded, and `err_frame` pulses.
- TOK: a to_fire with EOP ends the packet → GAP. `grant_to` clears on the same edge and `pkt_done` pulses.
- DATA:
  - Each lt_fire increments `byte_cnt`.
  - An SOP on a non-first beat pulses `err_frame`; the beat is still forwarded.
  - lt_fire with EOP → GAP, with `pkt_done`.
  - lt_fire with `m_lt_cancle` and no EOP → DROP.
  - lt_fire with `m_lt_cancle` and EOP → GAP, with no `pkt_done`.
  - A fire while `byte_cnt == MAX_PKT_BYTES` (i.e. beat MAX+1) pulses `err_len`. That beat is forwarded with cancel, then the packet goes to DROP (or GAP if the beat is EOP).
- DROP:
  - `grant_lt` is 0 and `m_lt_valid` is 0.
  - Source beats are consumed with `s_lt_ready=1`.
  - A consumed EOP → GAP, with no `pkt_done`.
- GAP:
  - `gap_cnt` loads IPG_CYCLES-1 on entry and decrements each cycle.
  - At 0 → IDLE.
  - Both grants are 0 during GAP.
  - `tx_data_on` holds its last value until the next grant.
- Reset (`rst`=1 at an edge): state IDLE, all grants 0, `tx_data_on`=0, counters 0, all pulses 0.
  - Reset mid-packet abandons the packet with no cancel issued.
  - `s_*_ready` = 0 from the cycle after reset.

## Timing
- Grant latency: SOP presented in IDLE at cycle N gives the grant and `tx_data_on` at N+1. The first beat can transfer at N+1.
- Within a packet, throughput is one beat per cycle when `m_*_ready`=1. Backpressure passes through combinationally.
- `tx_data_on` never changes while `grant_to` or `grant_lt` is set.
- Gap: after an EOP fire at cycle N, state is GAP for N+1..N+IPG_CYCLES. The next SOP can be granted at N+IPG_CYCLES and transfer at N+IPG_CYCLES+1.
- Pulses (`pkt_done`, `err_*`) are registered and high for exactly the cycle after the triggering fire.
- Outputs from reset:
  - Registered: `tx_data_on`=0, `busy`=0, `pkt_done`=0, `err_frame`=0, `err_len`=0.
  - Combinational: `s_to_ready`, `s_lt_ready`, `m_to_valid`, `m_lt_valid`, `m_lt_cancle` are all 0.

## Test plan
- Token: 3-beat token (SOP..EOP), `m_to_ready`=1, IPG 4 → `tx_data_on` stays 0; beats pass on consecutive cycles; `pkt_done` 1 cycle after EOP; `busy` low 4 cycles after the EOP fire.
- Simultaneous: both sources assert SOP the same cycle → token is granted first. After its EOP + 4 gap cycles, `tx_data_on`=1 and the data packet flows.
- Data with backpressure: 10-beat data packet, `m_lt_ready` toggling 1010... → `s_lt_ready` mirrors it while granted; all 10 beats forwarded in order; `pkt_done` once; `byte_cnt` reaches 10.
- Overflow: MAX_PKT_BYTES=8, 12-beat packet → beat 9 is forwarded with `m_lt_cancle`=1 and `err_len` pulses; beats 10–12 are consumed with `m_lt_valid`=0; no `pkt_done`; GAP then IDLE.
- Framing: data beat without SOP in IDLE → consumed, `err_frame` pulse, no grant. SOP on beat 3 of a granted packet → `err_frame`, beat still forwarded.
- Reset mid-DATA: assert `rst` at beat 5 → next cycle all grants, valids and readies are 0, `tx_data_on`=0; a fresh token packet then completes normally.
